// File: rtl/event_nack_scheduler.sv
// event_nack_scheduler
// Sits in memclk between the nack crossing FIFO and the readout generator.
// Queues nack requests, splits fragment re-reads into chunks of at most
// MAX_QW qwords and forces HOLDOFF_CYCLES+1 idle cycles after every issued
// nack so regular event readout keeps access to the datamover.
// Optional build macro: NACK_DEDUP_EN drops a request identical to the
// previously accepted one (bit 19 ignored) instead of queueing it.
module event_nack_scheduler #(
  parameter int FIFO_DEPTH     = 16,
  parameter int MAX_QW         = 512,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic        memclk,
  input  logic        memresetn,
  input  logic [47:0] s_nack_tdata,
  input  logic        s_nack_tvalid,
  output logic        s_nack_tready,
  output logic [47:0] m_nack_tdata,
  output logic        m_nack_tvalid,
  input  logic        m_nack_tready,
  output logic        busy_o,
  output logic [15:0] nack_count_o,
  output logic [15:0] cmd_count_o,
  output logic [7:0]  drop_count_o,
  output logic        wrap_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES);
  localparam logic [10:0]   MAX_LEN   = 11'(MAX_QW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_HOLD
  } state_t;

  // Queue entry packs the meaningful request bits: {[46:20], [18:0]}
  logic [45:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          q_empty;
  logic          q_full;
  logic          q_push;
  logic          q_pop;
  logic          accept;
  logic          dup;
  logic [45:0]   in_entry;
  logic [45:0]   head;
  logic          unused_in;

  state_t        state;
  logic          w_full;
  logic [2:0]    w_rsv;
  logic [10:0]   w_len;
  logic [11:0]   w_upper;
  logic [18:0]   w_off;
  logic [10:0]   chunk_len;
  logic [10:0]   next_chunk;
  logic [19:0]   off_sum;
  logic [HW-1:0] hold_cnt;
  logic          zero_drop;
  logic [1:0]    drop_inc;

  // Saturating add for the 8-bit drop statistic (up to two drops per cycle)
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign in_entry      = {s_nack_tdata[46:20], s_nack_tdata[18:0]};
  assign unused_in     = s_nack_tdata[47] ^ s_nack_tdata[19];
  assign head          = mem[rd_ptr];
  assign q_empty       = (occ == '0);
  assign q_full        = (occ == DEPTH_CNT);
  assign s_nack_tready = !q_full;
  assign accept        = s_nack_tvalid && s_nack_tready;
  assign q_push        = accept && !dup;
  assign q_pop         = (state == S_IDLE) && !q_empty;
  assign busy_o        = (state != S_IDLE) || !q_empty;

  assign next_chunk = (w_len > MAX_LEN) ? MAX_LEN : w_len;
  assign off_sum    = {1'b0, w_off} + {6'b0, chunk_len, 3'b0};
  assign zero_drop  = (state == S_LOAD) && !w_full && (w_len == 11'd0);
  assign drop_inc   = {1'b0, accept && dup} + {1'b0, zero_drop};

`ifdef NACK_DEDUP_EN
  logic [45:0] last_entry;
  logic        last_vld;

  assign dup = last_vld && (in_entry == last_entry);

  // Remember the last accepted request; forget it once everything has drained
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      last_vld <= 1'b0;
    end else if (accept) begin
      last_vld   <= 1'b1;
      last_entry <= in_entry;
    end else if (q_empty && (state == S_IDLE)) begin
      last_vld <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Queue storage write port
  always_ff @(posedge memclk) begin
    if (q_push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop keeps occupancy
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({q_push, q_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Issue FSM: pop, build a chunk, hand it over, then hold off
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      state         <= S_IDLE;
      m_nack_tvalid <= 1'b0;
      m_nack_tdata  <= '0;
      cmd_count_o   <= '0;
      wrap_err_o    <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            w_full  <= head[45];
            w_rsv   <= head[44:42];
            w_len   <= head[41:31];
            w_upper <= head[30:19];
            w_off   <= head[18:0];
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_full) begin
            // Full-event nacks go out untouched; len drops to zero on handshake
            chunk_len     <= w_len;
            m_nack_tdata  <= {1'b0, 1'b1, w_rsv, w_len, w_upper, 1'b0, w_off};
            m_nack_tvalid <= 1'b1;
            state         <= S_ISSUE;
          end else if (w_len == 11'd0) begin
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            chunk_len     <= next_chunk;
            m_nack_tdata  <= {1'b0, 1'b0, 3'b000, next_chunk, w_upper, 1'b0, w_off};
            m_nack_tvalid <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_nack_tready) begin
            m_nack_tvalid <= 1'b0;
            cmd_count_o   <= cmd_count_o + 16'd1;
            w_len         <= w_len - chunk_len;
            w_off         <= off_sum[18:0];
            if (off_sum[19]) wrap_err_o <= 1'b1;
            hold_cnt      <= '0;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ((w_len != 11'd0) && !w_full) ? S_LOAD : S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accept and drop statistics
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      nack_count_o <= '0;
      drop_count_o <= '0;
    end else begin
      if (accept) nack_count_o <= nack_count_o + 16'd1;
      drop_count_o <= sat_add8(drop_count_o, drop_inc);
    end
  end

endmodule

// File: tb/tb_event_nack_scheduler.sv
// tb_event_nack_scheduler
// Scoreboard bench: accepted requests are expanded into expected output
// nacks by a reference model; a monitor pops and compares on each handshake.
// Build with NACK_DEDUP_EN defined to exercise the duplicate-drop variant.
module tb_event_nack_scheduler;

  localparam int FD = 16;
  localparam int MQ = 512;
  localparam int HO = 4;

  logic        memclk = 1'b0;
  logic        memresetn = 1'b0;
  logic [47:0] s_nack_tdata = '0;
  logic        s_nack_tvalid = 1'b0;
  logic        s_nack_tready;
  logic [47:0] m_nack_tdata;
  logic        m_nack_tvalid;
  logic        m_nack_tready = 1'b0;
  logic        busy_o;
  logic [15:0] nack_count_o;
  logic [15:0] cmd_count_o;
  logic [7:0]  drop_count_o;
  logic        wrap_err_o;

  event_nack_scheduler #(
    .FIFO_DEPTH(FD),
    .MAX_QW(MQ),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .memclk(memclk),
    .memresetn(memresetn),
    .s_nack_tdata(s_nack_tdata),
    .s_nack_tvalid(s_nack_tvalid),
    .s_nack_tready(s_nack_tready),
    .m_nack_tdata(m_nack_tdata),
    .m_nack_tvalid(m_nack_tvalid),
    .m_nack_tready(m_nack_tready),
    .busy_o(busy_o),
    .nack_count_o(nack_count_o),
    .cmd_count_o(cmd_count_o),
    .drop_count_o(drop_count_o),
    .wrap_err_o(wrap_err_o)
  );

  always #5 memclk = ~memclk;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];
  int m_nack = 0;
  int m_cmd  = 0;
  int m_drop = 0;
  bit m_wrap = 1'b0;
  int rdy_mode = 1;
`ifdef NACK_DEDUP_EN
  bit          dd_vld = 1'b0;
  logic [45:0] dd_last;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input bit full, input int len, input int upper, input int off);
    logic [47:0] d;
    d = '0;
    d[46]    = full;
    d[42:32] = len[10:0];
    d[31:20] = upper[11:0];
    d[18:0]  = off[18:0];
    return d;
  endfunction

  // Reference model: expand one accepted request into its expected outputs
  task automatic model_accept(input logic [47:0] d);
    int len, upper, off, c;
    logic [47:0] o;
    bit skip;
    skip = 1'b0;
    m_nack++;
`ifdef NACK_DEDUP_EN
    if (dd_vld && ({d[46:20], d[18:0]} == dd_last)) begin
      skip = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    dd_vld  = 1'b1;
    dd_last = {d[46:20], d[18:0]};
`endif
    if (!skip) begin
      len   = int'(d[42:32]);
      upper = int'(d[31:20]);
      off   = int'(d[18:0]);
      if (d[46]) begin
        o = d;
        o[47] = 1'b0;
        o[19] = 1'b0;
        exp_q.push_back(o);
        m_cmd++;
        if (off + len * 8 >= 524288) m_wrap = 1'b1;
      end else if (len == 0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        while (len > 0) begin
          c = (len < MQ) ? len : MQ;
          exp_q.push_back(mk(1'b0, c, upper, off));
          m_cmd++;
          off = off + c * 8;
          if (off >= 524288) begin
            m_wrap = 1'b1;
            off = off - 524288;
          end
          len = len - c;
        end
      end
    end
  endtask

  // Present a request until accepted or limit cycles pass; ends at posedge+1
  task automatic send(input logic [47:0] d, input int limit, output bit ok);
    ok = 1'b0;
    s_nack_tdata  = d;
    s_nack_tvalid = 1'b1;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge memclk);
      if (s_nack_tready) begin
        model_accept(d);
        ok = 1'b1;
      end
      @(posedge memclk);
      #1;
    end
    s_nack_tvalid = 1'b0;
  endtask

  task automatic send_ok(input logic [47:0] d);
    bit ok;
    send(d, 2000, ok);
    check("send accepted", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge memclk);
      if (!busy_o && !m_nack_tvalid && exp_q.size() == 0) done = 1'b1;
      @(posedge memclk);
      #1;
    end
    check("drain within budget", {63'd0, done}, 64'd1);
`ifdef NACK_DEDUP_EN
    dd_vld = 1'b0;
`endif
  endtask

  task automatic counters_check(input string tag);
    @(negedge memclk);
    check({tag, " nack_count"}, nack_count_o, m_nack[15:0]);
    check({tag, " cmd_count"},  cmd_count_o,  m_cmd[15:0]);
    check({tag, " drop_count"}, drop_count_o, m_drop[7:0]);
    check({tag, " wrap_err"},   wrap_err_o,   m_wrap);
    @(posedge memclk);
    #1;
  endtask

  // Ready driver for the readout-generator side
  always @(posedge memclk) begin
    #1;
    case (rdy_mode)
      0:       m_nack_tready = 1'b0;
      1:       m_nack_tready = 1'b1;
      default: m_nack_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every handshake against the scoreboard, check hold stability
  bit          stall_prev = 1'b0;
  logic [47:0] prev_data;
  always @(negedge memclk) begin
    if (memresetn) begin
      if (stall_prev) begin
        check("hold valid", {63'd0, m_nack_tvalid}, 64'd1);
        check("hold data", m_nack_tdata, prev_data);
      end
      if (m_nack_tvalid && m_nack_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected nack: got 0x%0h expected none", m_nack_tdata);
        end else begin
          check("nack data", m_nack_tdata, exp_q.pop_front());
        end
      end
      stall_prev = m_nack_tvalid && !m_nack_tready;
      prev_data  = m_nack_tdata;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    bit ok;
    int n, gap, acc, r, len, off;
    logic [15:0] nack_before;

    // Reset state
    memresetn = 1'b0;
    repeat (3) @(posedge memclk);
    @(negedge memclk);
    check("reset tvalid", {63'd0, m_nack_tvalid}, 64'd0);
    check("reset tdata", m_nack_tdata, 64'd0);
    check("reset busy", {63'd0, busy_o}, 64'd0);
    check("reset s_tready", {63'd0, s_nack_tready}, 64'd1);
    check("reset counters", {nack_count_o, cmd_count_o, drop_count_o, wrap_err_o}, 64'd0);
    @(posedge memclk);
    #1;
    memresetn = 1'b1;
    rdy_mode = 1;
    repeat (2) @(posedge memclk);
    #1;

    // Full event with ignored bits set: 3-edge latency, passed through
    d = mk(1'b1, 0, 12'h123, 19'h00ABC);
    d[47] = 1'b1;
    d[19] = 1'b1;
    d[45:43] = 3'b101;
    send_ok(d);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge memclk);
      n++;
      if (m_nack_tvalid) break;
      @(posedge memclk);
      #1;
    end
    check("full event latency", n, 3);
    @(posedge memclk);
    #1;
    wait_idle(200);
    counters_check("full");

    // Split 1200 qwords into 512/512/176 with 6 idle cycles between chunks
    send_ok(mk(1'b0, 1200, 12'h0AB, 19'h00100));
    for (int i = 0; i < 50; i++) begin
      @(negedge memclk);
      if (m_nack_tvalid && m_nack_tready) break;
      @(posedge memclk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge memclk);
        #1;
        @(negedge memclk);
        if (m_nack_tvalid) break;
        gap++;
      end
      check("chunk gap", gap, HO + 2);
    end
    @(posedge memclk);
    #1;
    wait_idle(200);
    counters_check("split");

    // Zero-length fragment is dropped
    send_ok(mk(1'b0, 0, 12'h055, 19'h01000));
    wait_idle(200);
    counters_check("zero len");

    // Offset carry past 19 bits sets the sticky wrap flag
    send_ok(mk(1'b0, 64, 12'h001, 19'h7FF00));
    wait_idle(200);
    counters_check("wrap");

    // Backpressure: 1 working + FD queued accepted, then s_nack_tready low
    rdy_mode = 0;
    repeat (2) @(posedge memclk);
    #1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(mk(1'b0, 1 + i, 12'h200 + i, i * 16), 8, ok);
      if (!ok) break;
      acc++;
    end
    check("accepts before full", acc, FD + 1);
    @(negedge memclk);
    check("s_tready when full", {63'd0, s_nack_tready}, 64'd0);
    @(posedge memclk);
    #1;
    rdy_mode = 1;
    wait_idle(2000);
    counters_check("backpressure");

    // Randomized traffic with random ready
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        len = $urandom_range(0, 2047);
        off = $urandom_range(0, 32'h7BFFF);
        d = mk(1'b1, len, $urandom_range(0, 4095), off);
      end else if (r < 3) begin
        d = mk(1'b0, 0, $urandom_range(0, 4095), $urandom_range(0, 32'h7FFFF));
      end else begin
        d = mk(1'b0, $urandom_range(1, 2047), $urandom_range(0, 4095), $urandom_range(0, 32'h7FFFF));
      end
      send_ok(d);
      repeat ($urandom_range(0, 3)) @(posedge memclk);
      #1;
    end
    wait_idle(20000);
    rdy_mode = 1;
    counters_check("random");

    // Same request twice back-to-back
    nack_before = nack_count_o;
    d = mk(1'b0, 100, 12'h0CD, 19'h00200);
    send_ok(d);
    send_ok(d);
    wait_idle(500);
    check("repeat nack delta", nack_count_o - nack_before, 16'd2);
    counters_check("repeat");

    // Reset while issuing with entries still queued
    rdy_mode = 0;
    repeat (2) @(posedge memclk);
    #1;
    for (int i = 0; i < 6; i++) begin
      send(mk(1'b0, 8 + i, 12'h300 + i, i * 64), 8, ok);
      check("pre-reset accept", {63'd0, ok}, 64'd1);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge memclk);
      if (m_nack_tvalid) ok = 1'b1;
      @(posedge memclk);
      #1;
    end
    check("issuing before reset", {63'd0, ok}, 64'd1);
    memresetn = 1'b0;
    @(posedge memclk);
    @(negedge memclk);
    check("mid reset tvalid", {63'd0, m_nack_tvalid}, 64'd0);
    check("mid reset busy", {63'd0, busy_o}, 64'd0);
    check("mid reset counters", {nack_count_o, cmd_count_o, drop_count_o, wrap_err_o}, 64'd0);
    exp_q.delete();
    m_nack = 0;
    m_cmd  = 0;
    m_drop = 0;
    m_wrap = 1'b0;
`ifdef NACK_DEDUP_EN
    dd_vld = 1'b0;
`endif
    @(posedge memclk);
    #1;
    memresetn = 1'b1;
    rdy_mode = 1;
    repeat (40) @(posedge memclk);
    #1;
    counters_check("after reset");
    @(negedge memclk);
    check("after reset busy", {63'd0, busy_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
